// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq slice: function codes and flag bit positions.
// Saturating add is selected elsewhere by the ALU_SAT_EN macro.
package alu_pkg;

    typedef enum logic [1:0] {
        FN_AND  = 2'b00,
        FN_OR   = 2'b01,
        FN_NOTB = 2'b10,
        FN_ADD  = 2'b11
    } alu_fn_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand conditioning, function select and {V,C,N,Z} flags.
// Define ALU_SAT_EN to compile in saturating ADD (in_sat); otherwise ADD always wraps.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_src_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       f_i,
    input  logic             inva_i,
    input  logic             ena_i,
    input  logic             enb_i,
    input  logic             cin_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic             ovf;

`ifndef ALU_SAT_EN
    logic unused_sat;
    assign unused_sat = sat_i;
`endif

    always_comb begin
        a_eff    = (ena_i ? a_src_i : '0) ^ {WIDTH{inva_i}};
        b_eff    = enb_i ? b_i : '0;
        sum      = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_i};
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (alu_fn_e'(f_i))
            FN_AND:  result_o = a_eff & b_eff;
            FN_OR:   result_o = a_eff | b_eff;
            FN_NOTB: result_o = ~b_eff;
            FN_ADD: begin
                result_o = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                // C and V always describe the raw sum, even when the result saturates
                ovf      = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != a_eff[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (sat_i && sum[WIDTH]) begin
                    result_o = '1;
                end
`endif
            end
            default: result_o = '0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (result_o == '0);
        flags_o[FLAG_N] = result_o[WIDTH-1];
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_seq.sv
// Valid/ready wrapped ALU with registered result/flags and an internal accumulator.
// Saturating ADD is available when built with ALU_SAT_EN; the port list does not change.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_f,
    input  logic             in_inva,
    input  logic             in_ena,
    input  logic             in_enb,
    input  logic             in_cin,
    input  logic             in_use_acc,
    input  logic             in_clr_acc,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic [3:0]       out_flags_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             accept;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // a_src reads the pre-clear accumulator, so clear and use_acc may coincide
    assign a_src    = in_use_acc ? acc_q : in_a;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_src_i  (a_src),
        .b_i      (in_b),
        .f_i      (in_f),
        .inva_i   (in_inva),
        .ena_i    (in_ena),
        .enb_i    (in_enb),
        .cin_i    (in_cin),
        .sat_i    (in_sat),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    always_comb begin
        acc_d = acc_q;
        if (in_clr_acc) begin
            acc_d = '0;
        end else if (accept) begin
            acc_d = core_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            acc_q        <= '0;
        end else begin
            acc_q <= acc_d;
            if (accept) begin
                out_valid_q  <= 1'b1;
                out_result_q <= core_result;
                out_flags_q  <= core_flags;
            end else if (out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed scenarios plus randomized traffic
// against an arithmetic reference model; honours ALU_SAT_EN when defined.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_f;
    logic       in_inva;
    logic       in_ena;
    logic       in_enb;
    logic       in_cin;
    logic       in_use_acc;
    logic       in_clr_acc;
    logic       in_sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit         m_valid;
    logic [7:0] m_result;
    logic [3:0] m_flags;
    logic [7:0] m_acc;

    alu_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_f       (in_f),
        .in_inva    (in_inva),
        .in_ena     (in_ena),
        .in_enb     (in_enb),
        .in_cin     (in_cin),
        .in_use_acc (in_use_acc),
        .in_clr_acc (in_clr_acc),
        .in_sat     (in_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Integer-arithmetic view of the ALU: signed overflow judged by range, carry by magnitude.
    function automatic void ref_alu(input logic [7:0] asrc, input logic [7:0] b, input logic [1:0] f,
                                    input bit inva, input bit ena, input bit enb, input bit cin,
                                    input bit sat, output logic [7:0] r, output logic [3:0] fl);
        int ae, be, s, sa, sb, ss;
        bit c, v;
        ae = ena ? int'(asrc) : 0;
        if (inva) ae = 255 - ae;
        be = enb ? int'(b) : 0;
        c = 1'b0;
        v = 1'b0;
        s = 0;
        case (f)
            2'd0: r = 8'(ae & be);
            2'd1: r = 8'(ae | be);
            2'd2: r = 8'(255 - be);
            default: begin
                s  = ae + be + int'(cin);
                c  = (s > 255);
                sa = (ae > 127) ? ae - 256 : ae;
                sb = (be > 127) ? be - 256 : be;
                ss = sa + sb + int'(cin);
                v  = (ss > 127) || (ss < -128);
                r  = 8'(s % 256);
`ifdef ALU_SAT_EN
                if (sat && c) r = 8'hFF;
`else
                if (sat) r = 8'(s % 256);
`endif
            end
        endcase
        fl = {v, c, r[7], (r == 8'h00)};
    endfunction

    task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                          input bit inva, input bit cin, input bit use_acc, input bit sat);
        in_a       = a;
        in_b       = b;
        in_f       = f;
        in_inva    = inva;
        in_ena     = 1'b1;
        in_enb     = 1'b1;
        in_cin     = cin;
        in_use_acc = use_acc;
        in_sat     = sat;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic cycle();
        logic [7:0] asrc;
        logic [7:0] r;
        logic [3:0] fl;
        bit         acc;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        @(posedge clk);
        acc = in_valid && (!m_valid || out_ready);
        if (acc) begin
            asrc = in_use_acc ? m_acc : in_a;
            ref_alu(asrc, in_b, in_f, in_inva, in_ena, in_enb, in_cin, in_sat, r, fl);
            m_result = r;
            m_flags  = fl;
            m_valid  = 1'b1;
            m_acc    = r;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (in_clr_acc) m_acc = 8'h00;
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_result", 64'(out_result), 64'(m_result));
        chk("out_flags", 64'(out_flags), 64'(m_flags));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_valid  = 1'b0;
        m_result = 8'h00;
        m_flags  = 4'h0;
        m_acc    = 8'h00;
        #3;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_result", 64'(out_result), 64'h0);
        chk("rst_flags", 64'(out_flags), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] held;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_clr_acc = 1'b0;
        set_op(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        do_reset();

        // signed overflow into the sign bit
        in_valid = 1'b1;
        set_op(8'h7F, 8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("ovf_result", 64'(out_result), 64'h80);
        chk("ovf_flags", 64'(out_flags), 64'b1010);

        // inverted A plus carry-in wraps to zero
        set_op(8'h05, 8'h05, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("zero_result", 64'(out_result), 64'h00);
        chk("zero_flags", 64'(out_flags), 64'b0101);

        // saturation request
        set_op(8'hF0, 8'h20, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
`ifdef ALU_SAT_EN
        chk("sat_result", 64'(out_result), 64'hFF);
        chk("sat_flags", 64'(out_flags), 64'b0110);
`else
        chk("sat_result", 64'(out_result), 64'h10);
        chk("sat_flags", 64'(out_flags), 64'b0100);
`endif

        // logic functions
        set_op(8'hCA, 8'h0F, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        set_op(8'hCA, 8'h0F, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        set_op(8'hCA, 8'h0F, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        chk("notb_result", 64'(out_result), 64'hF0);

        // backpressure: first op accepted, second held off for three cycles
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(8'h11, 8'h22, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        held = out_result;
        chk("stall_first", 64'(held), 64'h33);
        set_op(8'h40, 8'h04, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold", 64'(out_result), 64'(held));
            chk("stall_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        cycle();
        chk("stall_second", 64'(out_result), 64'h44);
        in_valid = 1'b0;
        cycle();
        chk("stall_drain", 64'(out_valid), 64'h0);
        chk("stall_retain", 64'(out_result), 64'h44);

        // accumulator chain
        do_reset();
        in_valid = 1'b1;
        set_op(8'hAA, 8'h03, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(); chk("acc_1", 64'(out_result), 64'h03);
        cycle(); chk("acc_2", 64'(out_result), 64'h06);
        cycle(); chk("acc_3", 64'(out_result), 64'h09);
        in_clr_acc = 1'b1;
        cycle(); chk("acc_preclear", 64'(out_result), 64'h0C);
        in_clr_acc = 1'b0;
        cycle(); chk("acc_after_clr", 64'(out_result), 64'h03);
        in_valid   = 1'b0;
        in_clr_acc = 1'b1;
        cycle();
        in_clr_acc = 1'b0;
        in_valid   = 1'b1;
        cycle(); chk("acc_pulse_clr", 64'(out_result), 64'h03);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_clr_acc = ($urandom_range(0, 15) == 0);
            in_a       = 8'($urandom);
            in_b       = 8'($urandom);
            in_f       = 2'($urandom);
            in_inva    = 1'($urandom);
            in_ena     = ($urandom_range(0, 7) != 0);
            in_enb     = ($urandom_range(0, 7) != 0);
            in_cin     = 1'($urandom);
            in_use_acc = 1'($urandom);
            in_sat     = 1'($urandom);
            cycle();
        end

        // asynchronous reset while a result is stalled
        in_clr_acc = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        set_op(8'h21, 8'h12, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("pre_rst_valid", 64'(out_valid), 64'h1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_result", 64'(out_result), 64'h0);
        chk("arst_flags", 64'(out_flags), 64'h0);
        chk("arst_ready", 64'(in_ready), 64'h1);
        m_valid  = 1'b0;
        m_result = 8'h00;
        m_flags  = 4'h0;
        m_acc    = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("post_rst_idle", 64'(out_valid), 64'h0);
        in_valid = 1'b1;
        set_op(8'h77, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        chk("post_rst_acc", 64'(out_result), 64'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 in_f  input  2  function: 00 AND, 01 OR, 10 NOT B, 11 ADD.
REQ-009 in_inva, in_ena, in_enb, in_cin  input  1 each  invert A, enable A, enable B, carry-in.
REQ-010 in_use_acc  input  1  take A source from accumulator instead of in_a.
REQ-011 in_clr_acc  input  1  clear accumulator.
REQ-012 in_sat  input  1  saturating ADD request (honoured only per REQ-033).
REQ-013 out_valid  output  1  result held for consumer.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 out_result  output  WIDTH  registered result.
REQ-016 out_flags  output  4  registered {V,C,N,Z}.

Function
REQ-017 a_src = in_use_acc ? acc : in_a; a_eff = (in_ena ? a_src : 0) XOR {WIDTH{in_inva}}; b_eff = in_enb ? in_b : 0.
REQ-018 AND: a_eff & b_eff; OR: a_eff | b_eff; NOT B: ~b_eff; ADD: a_eff + b_eff + in_cin, WIDTH+1-bit sum, low WIDTH bits as result.
REQ-019 Z = result all zero; N = result MSB; C = sum bit WIDTH for ADD, else 0; V = signed overflow (operand MSBs equal, result MSB differs) for ADD, else 0.
REQ-020 in_ready = !out_valid || out_ready, combinational, no dependency on in_valid.
REQ-021 Accept = in_valid && in_ready; on accept, out_result/out_flags load next edge, out_valid = 1; latency exactly 1 cycle.
REQ-022 Accept while out_valid && out_ready: new result replaces old same edge, out_valid stays 1; full throughput one op/cycle.
REQ-023 out_valid && !out_ready: out_result, out_flags, out_valid held stable; no accept.
REQ-024 out_ready && !accept: out_valid clears next edge; out_result/out_flags retain last value.
REQ-025 Accumulator acc (WIDTH, internal) loads the result on every accept, any function.
REQ-026 in_clr_acc sampled every cycle regardless of handshake; when 1, acc = 0 next edge, overriding a same-cycle accept update.
REQ-027 Operation accepted with in_clr_acc=1 and in_use_acc=1 uses pre-clear acc value as a_src.
REQ-028 Inputs ignored when no accept, except in_clr_acc.

Reset
REQ-029 rst_n low: out_valid=0, out_result=0, out_flags=0, acc=0, immediately, independent of clk.
REQ-030 Reset mid-stall discards held result; no output transaction after release until a new accept.
REQ-031 in_ready = 1 during and after reset (out_valid=0).

Configuration
REQ-032 Macro ALU_SAT_EN compiles in saturating add; port list identical either way.
REQ-033 Defined: ADD with in_sat=1 and C=1 yields result all ones; Z/N computed on saturated result; C and V report raw sum.
REQ-034 Undefined: in_sat ignored, ADD always wraps modulo 2^WIDTH.

Structure
REQ-035 Shared package alu_pkg holds function codes (AND, OR, NOTB, ADD) and flag indices (Z=0, N=1, C=2, V=3).
REQ-036 Combinational datapath (REQ-017..019, 033) in sub-module alu_core, parametrised by WIDTH; alu_seq holds handshake, output registers, accumulator.

Verification (WIDTH=8)
REQ-037 ADD 0x7F+0x01, ena=enb=1, cin=0 -> next cycle out_result 0x80, flags V=1,C=0,N=1,Z=0.
REQ-038 ADD a=0x05 inva=1, b=0x05, cin=1 -> out_result 0x00, Z=1, C=1, V=0.
REQ-039 out_ready=0 for 3 cycles after one accept -> in_ready=0, second op held off, out_result stable; out_ready=1 -> second result next cycle, no op lost or duplicated.
REQ-040 From reset, 3x ADD use_acc=1, b=0x03 -> results 0x03, 0x06, 0x09; pulse in_clr_acc; next same op -> 0x03.
REQ-041 ADD 0xF0+0x20 in_sat=1 -> with ALU_SAT_EN 0xFF C=1; without 0x10 C=1.
REQ-042 rst_n low mid-cycle while stalled with out_valid=1 -> out_valid, out_result, acc zero before next clk edge.
